// File: rtl/audio_i2s_rx.sv
// I2S receiver for the codec ADC path: oversamples BCLK/LRCK/ADCDAT on CLK_50,
// assembles left/right words and presents them as a valid/ready pair.
module audio_i2s_rx #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              iCLK_50,
    input  logic              iRESET_n,
    input  logic              iCFG_OK,
    input  logic              iBCLK,
    input  logic              iLRCK,
    input  logic              iADCDAT,
    input  logic              iREADY,
    output logic              oVALID,
    output logic [DATA_W-1:0] oL_DATA,
    output logic [DATA_W-1:0] oR_DATA,
    output logic [15:0]       oSAMPLE_CNT,
    output logic              oOVERRUN,
    output logic              oFRAME_ERR
);

    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, ALIGN, SKIP, SHIFT, WAIT} state_t;

    state_t            state, state_nxt;
    logic              chan, chan_nxt;
    logic [2:0]        sync_q [SYNC_STAGES];
    logic              bclk_s, lrck_s, dat_s;
    logic              bclk_d, lrck_last;
    logic              bit_rise, lrck_edge, lrck_fall;
    logic [CW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shreg, shift_word, left_q;
    logic              cnt_clr, shift_en, word_done, ferr_set;
    logic              pair_done, left_done, accept, load;

    // Each stage carries {BCLK, LRCK, ADCDAT} so all three see identical delay.
    always_ff @(posedge iCLK_50 or negedge iRESET_n) begin
        if (!iRESET_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {iBCLK, iLRCK, iADCDAT};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign bclk_s = sync_q[SYNC_STAGES-1][2];
    assign lrck_s = sync_q[SYNC_STAGES-1][1];
    assign dat_s  = sync_q[SYNC_STAGES-1][0];

    assign bit_rise  = bclk_s & ~bclk_d;
    assign lrck_edge = bit_rise & (lrck_s ^ lrck_last);
    assign lrck_fall = lrck_edge & ~lrck_s;

    always_ff @(posedge iCLK_50 or negedge iRESET_n) begin
        if (!iRESET_n) begin
            bclk_d    <= 1'b0;
            lrck_last <= 1'b0;
        end else begin
            bclk_d <= bclk_s;
            if (bit_rise) lrck_last <= lrck_s;
        end
    end

    always_ff @(posedge iCLK_50 or negedge iRESET_n) begin
        if (!iRESET_n) begin
            state <= IDLE;
            chan  <= 1'b0;
        end else begin
            state <= state_nxt;
            chan  <= chan_nxt;
        end
    end

    // The LRCK-edge rise carries the previous word's LSB (I2S one-bit delay);
    // it is dropped by not shifting it, so SKIP itself needs no further bit.
    always_comb begin
        state_nxt = state;
        chan_nxt  = chan;
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        word_done = 1'b0;
        ferr_set  = 1'b0;
        if (!iCFG_OK) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: state_nxt = ALIGN;
                ALIGN: begin
                    if (lrck_fall) begin
                        state_nxt = SKIP;
                        chan_nxt  = 1'b0;
                    end
                end
                SKIP: begin
                    cnt_clr   = 1'b1;
                    state_nxt = SHIFT;
                end
                SHIFT: begin
                    if (lrck_edge) begin
                        ferr_set = 1'b1;
                        if (lrck_fall) begin
                            state_nxt = SKIP;
                            chan_nxt  = 1'b0;
                        end else begin
                            state_nxt = ALIGN;
                        end
                    end else if (bit_rise) begin
                        shift_en = 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            word_done = 1'b1;
                            state_nxt = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (lrck_edge) begin
                        chan_nxt  = ~chan;
                        state_nxt = SKIP;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign shift_word = DATA_W'({shreg, dat_s});
    assign left_done  = word_done & ~chan;
    assign pair_done  = word_done & chan;
    assign accept     = oVALID & iREADY;
    assign load       = pair_done & (~oVALID | iREADY);

    always_ff @(posedge iCLK_50 or negedge iRESET_n) begin
        if (!iRESET_n) begin
            bit_cnt     <= '0;
            shreg       <= '0;
            left_q      <= '0;
            oVALID      <= 1'b0;
            oL_DATA     <= '0;
            oR_DATA     <= '0;
            oSAMPLE_CNT <= '0;
            oOVERRUN    <= 1'b0;
            oFRAME_ERR  <= 1'b0;
        end else begin
            if (cnt_clr) begin
                bit_cnt <= '0;
                shreg   <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 1'b1;
                shreg   <= shift_word;
            end
            if (left_done) left_q <= shift_word;
            if (load) begin
                oL_DATA <= left_q;
                oR_DATA <= shift_word;
                oVALID  <= 1'b1;
            end else if (accept) begin
                oVALID <= 1'b0;
            end
            if (accept)              oSAMPLE_CNT <= oSAMPLE_CNT + 16'd1;
            if (pair_done && !load)  oOVERRUN    <= 1'b1;
            if (ferr_set)            oFRAME_ERR  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_audio_i2s_rx.sv
// Directed bench for audio_i2s_rx: drives I2S frames (32 BCLK per channel,
// 16-bit MSB-first words) and checks pairs, counters and sticky flags.
`timescale 1ns/1ps
module tb_audio_i2s_rx;

    localparam int DATA_W      = 16;
    localparam int SYNC_STAGES = 2;
    localparam int CLK_P       = 20;
    localparam int BCLK_HALF   = 163;
    localparam longint LAT_MAX = (SYNC_STAGES + 2) * CLK_P;

    logic              iCLK_50 = 1'b0;
    logic              iRESET_n = 1'b0;
    logic              iCFG_OK = 1'b1;
    logic              iBCLK = 1'b0;
    logic              iLRCK = 1'b1;
    logic              iADCDAT = 1'b0;
    logic              iREADY = 1'b0;
    logic              oVALID;
    logic [DATA_W-1:0] oL_DATA, oR_DATA;
    logic [15:0]       oSAMPLE_CNT;
    logic              oOVERRUN, oFRAME_ERR;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          acc_n = 0;
    logic [15:0] acc_l = '0, acc_r = '0;
    time         t_last = 0, t_rise = 0;

    audio_i2s_rx #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
        .iCLK_50(iCLK_50), .iRESET_n(iRESET_n), .iCFG_OK(iCFG_OK),
        .iBCLK(iBCLK), .iLRCK(iLRCK), .iADCDAT(iADCDAT), .iREADY(iREADY),
        .oVALID(oVALID), .oL_DATA(oL_DATA), .oR_DATA(oR_DATA),
        .oSAMPLE_CNT(oSAMPLE_CNT), .oOVERRUN(oOVERRUN), .oFRAME_ERR(oFRAME_ERR)
    );

    always #(CLK_P/2) iCLK_50 = ~iCLK_50;

    always @(negedge iCLK_50) begin
        if (iRESET_n && oVALID && iREADY) begin
            acc_n = acc_n + 1;
            acc_l = oL_DATA;
            acc_r = oR_DATA;
        end
    end

    always @(posedge oVALID) t_rise = $time;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Slot 0 is the delayed-LSB slot; driven 1 so a capture of it shows up.
    task automatic send_slots(input logic lr, input logic [15:0] word, input int first, input int last);
        for (int s = first; s <= last; s++) begin
            iLRCK = lr;
            if (s == 0)       iADCDAT = 1'b1;
            else if (s <= 16) iADCDAT = word[16-s];
            else              iADCDAT = 1'b0;
            #BCLK_HALF;
            iBCLK = 1'b1;
            if (lr && s == 16) t_last = $time;
            #BCLK_HALF;
            iBCLK = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        send_slots(1'b0, l, 0, 31);
        send_slots(1'b1, r, 0, 31);
    endtask

    task automatic set_ready(input logic v);
        @(posedge iCLK_50);
        #1 iREADY = v;
    endtask

    task automatic apply_reset();
        iRESET_n = 1'b0;
        iCFG_OK  = 1'b1;
        iLRCK    = 1'b1;
        iBCLK    = 1'b0;
        iADCDAT  = 1'b0;
        #47;
        iRESET_n = 1'b1;
        #40;
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++; if (oVALID !== 1'b0)          begin tests_failed++; $display("FAIL reset_valid got=%0h exp=0", oVALID); end
        tests_run++; if (oL_DATA !== 16'h0)        begin tests_failed++; $display("FAIL reset_l got=%0h exp=0", oL_DATA); end
        tests_run++; if (oR_DATA !== 16'h0)        begin tests_failed++; $display("FAIL reset_r got=%0h exp=0", oR_DATA); end
        tests_run++; if (oSAMPLE_CNT !== 16'h0)    begin tests_failed++; $display("FAIL reset_cnt got=%0h exp=0", oSAMPLE_CNT); end
        tests_run++; if (oOVERRUN !== 1'b0)        begin tests_failed++; $display("FAIL reset_ovr got=%0h exp=0", oOVERRUN); end
        tests_run++; if (oFRAME_ERR !== 1'b0)      begin tests_failed++; $display("FAIL reset_ferr got=%0h exp=0", oFRAME_ERR); end
    endtask

    task automatic test_basic();
        int base;
        longint lat;
        apply_reset();
        set_ready(1'b1);
        send_slots(1'b1, 16'h0, 0, 31);
        base = acc_n;
        send_frame(16'h1234, 16'hABCD);
        lat = longint'(t_rise) - longint'(t_last);
        tests_run++; if (acc_n - base !== 1)       begin tests_failed++; $display("FAIL basic_pairs got=%0d exp=1", acc_n - base); end
        tests_run++; if (acc_l !== 16'h1234)       begin tests_failed++; $display("FAIL basic_l got=%0h exp=1234", acc_l); end
        tests_run++; if (acc_r !== 16'hABCD)       begin tests_failed++; $display("FAIL basic_r got=%0h exp=abcd", acc_r); end
        tests_run++; if (oSAMPLE_CNT !== 16'd1)    begin tests_failed++; $display("FAIL basic_cnt got=%0h exp=1", oSAMPLE_CNT); end
        tests_run++; if (oVALID !== 1'b0)          begin tests_failed++; $display("FAIL basic_pulse got=%0h exp=0", oVALID); end
        tests_run++; if (lat <= 0 || lat > LAT_MAX) begin tests_failed++; $display("FAIL basic_latency got=%0d ns exp=1..%0d ns", lat, LAT_MAX); end
    endtask

    task automatic test_back_to_back();
        send_frame(16'h8001, 16'h7FFE);
        tests_run++; if (acc_l !== 16'h8001)       begin tests_failed++; $display("FAIL b2b_l got=%0h exp=8001", acc_l); end
        tests_run++; if (acc_r !== 16'h7FFE)       begin tests_failed++; $display("FAIL b2b_r got=%0h exp=7ffe", acc_r); end
        tests_run++; if (oSAMPLE_CNT !== 16'd2)    begin tests_failed++; $display("FAIL b2b_cnt got=%0h exp=2", oSAMPLE_CNT); end
        tests_run++; if (oOVERRUN !== 1'b0)        begin tests_failed++; $display("FAIL b2b_ovr got=%0h exp=0", oOVERRUN); end
    endtask

    task automatic test_overrun();
        int base;
        apply_reset();
        iREADY = 1'b0;
        send_slots(1'b1, 16'h0, 0, 31);
        base = acc_n;
        send_frame(16'h0001, 16'h0002);
        tests_run++; if (oVALID !== 1'b1)          begin tests_failed++; $display("FAIL ovr_valid got=%0h exp=1", oVALID); end
        tests_run++; if (oOVERRUN !== 1'b0)        begin tests_failed++; $display("FAIL ovr_early got=%0h exp=0", oOVERRUN); end
        send_frame(16'h0003, 16'h0004);
        send_frame(16'h0005, 16'h0006);
        tests_run++; if (oL_DATA !== 16'h0001)     begin tests_failed++; $display("FAIL ovr_hold_l got=%0h exp=1", oL_DATA); end
        tests_run++; if (oR_DATA !== 16'h0002)     begin tests_failed++; $display("FAIL ovr_hold_r got=%0h exp=2", oR_DATA); end
        tests_run++; if (oOVERRUN !== 1'b1)        begin tests_failed++; $display("FAIL ovr_flag got=%0h exp=1", oOVERRUN); end
        tests_run++; if (oSAMPLE_CNT !== 16'd0)    begin tests_failed++; $display("FAIL ovr_cnt0 got=%0h exp=0", oSAMPLE_CNT); end
        set_ready(1'b1);
        repeat (3) @(negedge iCLK_50);
        tests_run++; if (acc_n - base !== 1)       begin tests_failed++; $display("FAIL ovr_pairs got=%0d exp=1", acc_n - base); end
        tests_run++; if (acc_l !== 16'h0001 || acc_r !== 16'h0002) begin tests_failed++; $display("FAIL ovr_acc got=%0h/%0h exp=1/2", acc_l, acc_r); end
        tests_run++; if (oSAMPLE_CNT !== 16'd1)    begin tests_failed++; $display("FAIL ovr_cnt1 got=%0h exp=1", oSAMPLE_CNT); end
        tests_run++; if (oVALID !== 1'b0)          begin tests_failed++; $display("FAIL ovr_clear got=%0h exp=0", oVALID); end
    endtask

    task automatic test_frame_err();
        int base;
        apply_reset();
        set_ready(1'b1);
        send_slots(1'b1, 16'h0, 0, 31);
        base = acc_n;
        send_slots(1'b0, 16'hFFFF, 0, 10);
        send_slots(1'b1, 16'h1111, 0, 31);
        tests_run++; if (oFRAME_ERR !== 1'b1)      begin tests_failed++; $display("FAIL ferr_flag got=%0h exp=1", oFRAME_ERR); end
        tests_run++; if (acc_n - base !== 0)       begin tests_failed++; $display("FAIL ferr_nopair got=%0d exp=0", acc_n - base); end
        send_frame(16'h5555, 16'hAAAA);
        tests_run++; if (acc_n - base !== 1)       begin tests_failed++; $display("FAIL ferr_pairs got=%0d exp=1", acc_n - base); end
        tests_run++; if (acc_l !== 16'h5555 || acc_r !== 16'hAAAA) begin tests_failed++; $display("FAIL ferr_data got=%0h/%0h exp=5555/aaaa", acc_l, acc_r); end
        tests_run++; if (oFRAME_ERR !== 1'b1)      begin tests_failed++; $display("FAIL ferr_sticky got=%0h exp=1", oFRAME_ERR); end
    endtask

    task automatic test_cfg_drop();
        int base;
        apply_reset();
        set_ready(1'b1);
        send_slots(1'b1, 16'h0, 0, 31);
        base = acc_n;
        send_frame(16'h1111, 16'h2222);
        send_slots(1'b0, 16'h3333, 0, 31);
        send_slots(1'b1, 16'h4444, 0, 8);
        iCFG_OK = 1'b0;
        send_slots(1'b1, 16'h4444, 9, 31);
        send_frame(16'h5151, 16'h5252);
        send_frame(16'h5353, 16'h5454);
        tests_run++; if (acc_n - base !== 1)       begin tests_failed++; $display("FAIL cfg_partial got=%0d exp=1", acc_n - base); end
        iCFG_OK = 1'b1;
        send_frame(16'h6161, 16'h6262);
        tests_run++; if (acc_n - base !== 2)       begin tests_failed++; $display("FAIL cfg_pairs got=%0d exp=2", acc_n - base); end
        tests_run++; if (acc_l !== 16'h6161 || acc_r !== 16'h6262) begin tests_failed++; $display("FAIL cfg_data got=%0h/%0h exp=6161/6262", acc_l, acc_r); end
        tests_run++; if (oSAMPLE_CNT !== 16'd2)    begin tests_failed++; $display("FAIL cfg_cnt got=%0h exp=2", oSAMPLE_CNT); end
        tests_run++; if (oFRAME_ERR !== 1'b0)      begin tests_failed++; $display("FAIL cfg_ferr got=%0h exp=0", oFRAME_ERR); end
    endtask

    task automatic test_reset_mid();
        int base;
        apply_reset();
        set_ready(1'b1);
        send_slots(1'b1, 16'h0, 0, 31);
        send_frame(16'h0909, 16'h0808);
        set_ready(1'b0);
        send_frame(16'h0A0A, 16'h0B0B);
        tests_run++; if (oVALID !== 1'b1)          begin tests_failed++; $display("FAIL rmid_pending got=%0h exp=1", oVALID); end
        send_slots(1'b0, 16'h0C0C, 0, 6);
        #3 iRESET_n = 1'b0;
        #1;
        tests_run++; if (oVALID !== 1'b0)          begin tests_failed++; $display("FAIL rmid_valid got=%0h exp=0", oVALID); end
        tests_run++; if (oL_DATA !== 16'h0 || oR_DATA !== 16'h0) begin tests_failed++; $display("FAIL rmid_data got=%0h/%0h exp=0/0", oL_DATA, oR_DATA); end
        tests_run++; if (oSAMPLE_CNT !== 16'h0)    begin tests_failed++; $display("FAIL rmid_cnt got=%0h exp=0", oSAMPLE_CNT); end
        #40 iRESET_n = 1'b1;
        set_ready(1'b1);
        base = acc_n;
        send_slots(1'b0, 16'h0C0C, 7, 31);
        send_slots(1'b1, 16'h0D0D, 0, 31);
        tests_run++; if (acc_n - base !== 0)       begin tests_failed++; $display("FAIL rmid_midframe got=%0d exp=0", acc_n - base); end
        send_frame(16'h0E0E, 16'h0F0F);
        tests_run++; if (acc_l !== 16'h0E0E || acc_r !== 16'h0F0F) begin tests_failed++; $display("FAIL rmid_data2 got=%0h/%0h exp=0e0e/0f0f", acc_l, acc_r); end
        tests_run++; if (oSAMPLE_CNT !== 16'd1)    begin tests_failed++; $display("FAIL rmid_cnt2 got=%0h exp=1", oSAMPLE_CNT); end
    endtask

    task automatic test_wrap();
        apply_reset();
        set_ready(1'b1);
        send_slots(1'b1, 16'h0, 0, 31);
        @(negedge iCLK_50);
        force dut.oSAMPLE_CNT = 16'hFFFE;
        @(negedge iCLK_50);
        release dut.oSAMPLE_CNT;
        send_frame(16'h0102, 16'h0304);
        tests_run++; if (oSAMPLE_CNT !== 16'hFFFF) begin tests_failed++; $display("FAIL wrap_ffff got=%0h exp=ffff", oSAMPLE_CNT); end
        send_frame(16'h0506, 16'h0708);
        tests_run++; if (oSAMPLE_CNT !== 16'h0000) begin tests_failed++; $display("FAIL wrap_zero got=%0h exp=0", oSAMPLE_CNT); end
        tests_run++; if (oOVERRUN !== 1'b0 || oFRAME_ERR !== 1'b0) begin tests_failed++; $display("FAIL wrap_flags got=%0h/%0h exp=0/0", oOVERRUN, oFRAME_ERR); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_overrun();
        test_frame_err();
        test_cfg_drop();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/audio_i2s_rx.md
AUDIO_I2S_RX -- requirements
Module: audio_i2s_rx

Interface
REQ-001 SHALL have parameter: DATA_W, 16, bits captured per channel (1..32).
REQ-002 SHALL have parameter: SYNC_STAGES, 2, synchronizer flops on each codec input.
REQ-003 SHALL have port: iCLK_50  in  1  system clock, 50 MHz.
REQ-004 SHALL have port: iRESET_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: iCFG_OK  in  1  codec configuration complete; high enables capture.
REQ-006 SHALL have port: iBCLK  in  1  codec bit clock, asynchronous, at most 6 MHz.
REQ-007 SHALL have port: iLRCK  in  1  codec frame clock, low = left, high = right.
REQ-008 SHALL have port: iADCDAT  in  1  codec serial ADC data, MSB first.
REQ-009 SHALL have port: iREADY  in  1  consumer accepts the pair when high with oVALID.
REQ-010 SHALL have port: oVALID  out  1  oL_DATA/oR_DATA hold an unaccepted pair.
REQ-011 SHALL have port: oL_DATA  out  DATA_W  left sample, two's complement.
REQ-012 SHALL have port: oR_DATA  out  DATA_W  right sample, two's complement.
REQ-013 SHALL have port: oSAMPLE_CNT  out  16  count of accepted pairs, wraps 0xFFFF->0.
REQ-014 SHALL have port: oOVERRUN  out  1  sticky: a completed pair was dropped.
REQ-015 SHALL have port: oFRAME_ERR  out  1  sticky: LRCK edge came before DATA_W bits.

Function
REQ-016 SHALL pass iBCLK, iLRCK, iADCDAT through SYNC_STAGES flops; all logic SHALL run on iCLK_50 only.
REQ-017 SHALL detect a BCLK rise as synced BCLK high with previous-cycle synced BCLK low; all bit events occur only on these cycles.
REQ-018 SHALL sample LRCK and ADCDAT on each BCLK rise; an LRCK edge is sampled LRCK differing from the previous BCLK rise's sample.
REQ-019 SHALL implement states IDLE, ALIGN, SKIP, SHIFT, WAIT.
REQ-020 IDLE: when iCFG_OK is high, go to ALIGN.
REQ-021 ALIGN: ignore bits until the LRCK 1->0 edge, then go to SKIP with channel = left.
REQ-022 SKIP: discard the one bit after an LRCK edge (I2S one-bit delay), clear the bit counter, go to SHIFT.
REQ-023 SHIFT: shift ADCDAT into the channel register MSB first and increment the bit counter; at DATA_W bits, latch the channel and go to WAIT.
REQ-024 WAIT: ignore bits until the next LRCK edge, then toggle channel and go to SKIP.
REQ-025 Right channel complete: if oVALID is low, or oVALID and iREADY are both high that cycle, load oL_DATA/oR_DATA and set oVALID on the next cycle.
REQ-026 Right channel complete while oVALID is high and iREADY is low: drop the new pair, keep the outputs, set oOVERRUN.
REQ-027 oVALID and iREADY both high: increment oSAMPLE_CNT; clear oVALID unless a new pair loads that same cycle.
REQ-028 oL_DATA/oR_DATA SHALL stay stable while oVALID is high.
REQ-029 An LRCK edge in SHIFT before DATA_W bits: set oFRAME_ERR, discard the partial frame, go to SKIP if the edge is 1->0, else ALIGN.
REQ-030 iCFG_OK low in any state: go to IDLE next cycle and discard the partial frame; a pending oVALID pair stays until accepted.
REQ-031 A pair SHALL contain a left sample and the right sample from the same LRCK period; a lone left sample is never output.
REQ-032 When DATA_W exceeds the codec word length, trailing bits SHALL be captured as sampled; no sign extension.
REQ-033 Latency: oVALID rises at most SYNC_STAGES+2 iCLK_50 cycles after the BCLK rise carrying the last right-channel bit.

Reset
REQ-034 iRESET_n low SHALL, asynchronously, set state IDLE, oVALID 0, oL_DATA 0, oR_DATA 0, oSAMPLE_CNT 0, oOVERRUN 0, oFRAME_ERR 0, and clear counters, synchronizers and channel registers.
REQ-035 oOVERRUN and oFRAME_ERR SHALL clear only on reset.
REQ-036 After reset release, capture SHALL start at the first LRCK 1->0 edge seen with iCFG_OK high, never mid-frame.

Verification
REQ-037 BCLK 3.072 MHz, 32-bit frames, iREADY=1, L=0x1234, R=0xABCD -> oVALID pulse, oL_DATA=0x1234, oR_DATA=0xABCD, oSAMPLE_CNT=1.
REQ-038 iREADY=0 for 3 frames with L/R=0x0001/0x0002, then 0x0003/0x0004, then 0x0005/0x0006 -> outputs hold 0x0001/0x0002, oOVERRUN=1; after iREADY=1, oSAMPLE_CNT=1.
REQ-039 LRCK toggles after 10 bits in a left channel -> oFRAME_ERR=1, no pair output for that frame, next full frame 0x5555/0xAAAA outputs correctly.
REQ-040 iCFG_OK dropped mid-right-channel, raised 2 frames later -> no partial pair; first pair after re-enable is a full frame's data.
REQ-041 Reset asserted mid-SHIFT with oVALID=1 -> all outputs 0 immediately; capture resumes at the next LRCK fall.
REQ-042 oSAMPLE_CNT preloaded by 65536 accepted pairs -> wraps to 0 with no flag.
